// File: rtl/radix2_div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package radix2_div_pkg;
  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [XLEN-1:0] XMIN = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] WMIN = 64'hFFFF_FFFF_8000_0000;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction
endpackage

// File: rtl/radix2_div_if.sv
// EX <-> divider stall handshake: EX holds start until it sees the ready pulse.
interface radix2_div_if;
  import radix2_div_pkg::*;
  logic            start;
  logic            is_signed;
  logic            is_word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ready;
  logic            error;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;

  modport master (output start, is_signed, is_word, a, b,
                  input  ready, error, q, r);
  modport slave  (input  start, is_signed, is_word, a, b,
                  output ready, error, q, r);
endinterface

// File: rtl/radix2_div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module div_step
  import radix2_div_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Shifted remainder needs 65 bits when the divisor magnitude exceeds 2^63;
  // when it fits, the true difference is below the divisor so 64 bits suffice.
  assign trial = {rem_i, quo_i[XLEN-1]};
  assign ge    = trial >= {1'b0, dvs_i};
  assign diff  = trial[XLEN-1:0] - dvs_i;
  assign rem_o = ge ? diff : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ge};
endmodule

// File: rtl/radix2_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
module radix2_div
  import radix2_div_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  radix2_div_if.slave dif
);
  div_state_e      state, state_n;
  logic [XLEN-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [XLEN-1:0] q_o, r_o;
  logic            err_o, neg_q, neg_r, word;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0] ea, eb, ma, mb, quo_ld;
  logic [XLEN-1:0] q_fix, r_fix, q_res, r_res;
  logic            sa, sb, is_zero, is_ovf, last;

  // Effective operands: W ops use the low halves, extended per signedness.
  always_comb begin
    ea      = dif.is_word ? (dif.is_signed ? sext32(dif.a[31:0]) : {32'b0, dif.a[31:0]}) : dif.a;
    eb      = dif.is_word ? (dif.is_signed ? sext32(dif.b[31:0]) : {32'b0, dif.b[31:0]}) : dif.b;
    sa      = dif.is_signed & ea[XLEN-1];
    sb      = dif.is_signed & eb[XLEN-1];
    ma      = sa ? -ea : ea;
    mb      = sb ? -eb : eb;
    quo_ld  = dif.is_word ? {ma[31:0], 32'b0} : ma;
    is_zero = (eb == '0);
    is_ovf  = dif.is_signed & (ea == (dif.is_word ? WMIN : XMIN)) & (eb == '1);
  end

  div_step u_step (
    .rem_i (rem),
    .quo_i (quo),
    .dvs_i (dvs),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  // Fixup on the final step's output so results are registered entering DONE.
  always_comb begin
    q_fix = neg_q ? -quo_n : quo_n;
    r_fix = neg_r ? -rem_n : rem_n;
    q_res = word ? sext32(q_fix[31:0]) : q_fix;
    r_res = word ? sext32(r_fix[31:0]) : r_fix;
    last  = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: if (dif.start) state_n = (is_zero | is_ovf) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: begin
        if (!dif.start) state_n = DIV_IDLE;
        else if (last)  state_n = DIV_DONE;
      end
      DIV_DONE: state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0; quo <= '0; dvs <= '0; cnt <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; word <= 1'b0;
      q_o <= '0; r_o <= '0; err_o <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (dif.start) begin
          rem   <= '0;
          quo   <= quo_ld;
          dvs   <= mb;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          word  <= dif.is_word;
          cnt   <= dif.is_word ? CNT_W'(32) : CNT_W'(64);
          if (is_zero) begin
            q_o   <= '1;
            r_o   <= dif.is_word ? sext32(ea[31:0]) : ea;
            err_o <= 1'b1;
          end else if (is_ovf) begin
            q_o   <= ea;
            r_o   <= '0;
            err_o <= 1'b0;
          end
        end
        DIV_BUSY: if (dif.start) begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            q_o   <= q_res;
            r_o   <= r_res;
            err_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dif.ready = (state == DIV_DONE);
  assign dif.error = err_o;
  assign dif.q     = q_o;
  assign dif.r     = r_o;
endmodule
